vga_pattern_gen: RTL and testbench

Parametrised successor to the fixed-mode VGA controller. Generates VGA timing from the system clock through a pixel clock-enable divider, and drives one of four selectable test patterns. The board buttons cycle the pattern and toggle colour inversion, and every change is applied at a frame boundary. It sits directly under the top level and drives the VGA connector pins.

---
 rtl/vga_pkg.sv | 21 ++
 rtl/vga_timing.sv | 86 ++++++++
 rtl/vga_pattern_gen.sv | 244 ++++++++++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared constants for the VGA pattern generator.
//   MODE_*    : pattern selector encodings (MODE_W bits wide)
//   BAR_TABLE : {R,G,B} enable flags for each of the 8 colour bars
// -----------------------------------------------------------------------------
package vga_pkg;

  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_BARS  = 2'd0;
  localparam logic [MODE_W-1:0] MODE_CHECK = 2'd1;
  localparam logic [MODE_W-1:0] MODE_GRAD  = 2'd2;
  localparam logic [MODE_W-1:0] MODE_SOLID = 2'd3;

  // Index 0 is the leftmost bar; bit 2 = red, bit 1 = green, bit 0 = blue.
  localparam logic [7:0][2:0] BAR_TABLE = {
    3'b111, 3'b110, 3'b101, 3'b100, 3'b011, 3'b010, 3'b001, 3'b000
  };

endpackage

// File: rtl/vga_timing.sv
// -----------------------------------------------------------------------------
// vga_timing
// Pixel clock-enable divider, horizontal/vertical raster counters and the
// combinational sync/active decode of the current counter position.
//   clk, rst    : system clock, synchronous active-high reset
//   o_pix_ce    : one-clk pixel tick, every CLK_DIV clocks
//   o_h, o_v    : current raster position
//   o_hs_act    : h inside the hsync pulse (polarity-free)
//   o_vs_act    : v inside the vsync pulse (polarity-free)
//   o_active    : position is inside the visible area
// -----------------------------------------------------------------------------
module vga_timing #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW = $clog2(H_TOTAL),
  localparam int VW = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          o_pix_ce,
  output logic [HW-1:0] o_h,
  output logic [VW-1:0] o_v,
  output logic          o_hs_act,
  output logic          o_vs_act,
  output logic          o_active
);

  // A divide-by-1 still needs a one-bit counter to keep the port widths legal.
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);

  logic [DW-1:0] r_div;
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic          w_pix_ce;

  assign w_pix_ce = (r_div == DIV_LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= '0;
    end else if (w_pix_ce) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_pix_ce) begin
      if (r_h == H_LAST) begin
        r_h <= '0;
        r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
      end else begin
        r_h <= r_h + 1'b1;
      end
    end
  end

  assign o_pix_ce = w_pix_ce;
  assign o_h      = r_h;
  assign o_v      = r_v;
  assign o_hs_act = (32'(r_h) >= H_ACTIVE + H_FP) &&
                    (32'(r_h) <  H_ACTIVE + H_FP + H_SYNC);
  assign o_vs_act = (32'(r_v) >= V_ACTIVE + V_FP) &&
                    (32'(r_v) <  V_ACTIVE + V_FP + V_SYNC);
  assign o_active = (32'(r_h) < H_ACTIVE) && (32'(r_v) < V_ACTIVE);

endmodule

// File: rtl/vga_pattern_gen.sv
// -----------------------------------------------------------------------------
// vga_pattern_gen
// VGA timing plus four selectable test patterns (colour bars, checkerboard,
// horizontal gradient, solid white) with optional colour inversion. Button
// presses stage a new mode/invert setting that is applied at frame start.
//   clk, rst          : system clock, synchronous active-high reset
//   bt[2:0]           : raw buttons, [0] next mode, [1] previous mode,
//                       [2] toggle invert
//   hsync, vsync      : sync outputs, polarity set by H_POL / V_POL
//   red, green, blue  : COLOR_W-bit colour channels, 0 while blanking
//   de                : active-video flag, aligned with the colours
//   frame_start       : one-clk pulse after the pixel tick at h=0, v=0
// Build option: define VGA_BORDER_EN to draw a one-pixel white frame around
// the visible area (inverted along with the pattern).
// -----------------------------------------------------------------------------
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned COLOR_W  = 3,
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW = $clog2(H_TOTAL),
  localparam int VW = $clog2(V_TOTAL)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         bt,
  output logic               hsync,
  output logic               vsync,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               de,
  output logic               frame_start
);

  localparam int unsigned BAR_W = H_ACTIVE / 8;
  localparam int unsigned XB    = $clog2(H_ACTIVE);

  // Timing
  logic          w_pix_ce;
  logic [HW-1:0] w_h;
  logic [VW-1:0] w_v;
  logic          w_hs_act;
  logic          w_vs_act;
  logic          w_active;
  logic          w_frame_tick;

  vga_timing #(
    .CLK_DIV (CLK_DIV),
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk     (clk),
    .rst     (rst),
    .o_pix_ce(w_pix_ce),
    .o_h     (w_h),
    .o_v     (w_v),
    .o_hs_act(w_hs_act),
    .o_vs_act(w_vs_act),
    .o_active(w_active)
  );

  assign w_frame_tick = w_pix_ce && (w_h == '0) && (w_v == '0);

  // Button synchroniser and rising-edge detect
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic [2:0] r_btn_d;
  logic [2:0] w_edge;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_btn_d <= '0;
    end else begin
      r_sync1 <= bt;
      r_sync2 <= r_sync1;
      r_btn_d <= r_sync2;
    end
  end

  assign w_edge = r_sync2 & ~r_btn_d;

  // Staged mode / invert control
  logic [MODE_W-1:0] r_pend_mode;
  logic [MODE_W-1:0] r_act_mode;
  logic              r_pend_inv;
  logic              r_act_inv;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_mode <= MODE_BARS;
      r_act_mode  <= MODE_BARS;
      r_pend_inv  <= 1'b0;
      r_act_inv   <= 1'b0;
    end else begin
      // Simultaneous next+prev cancel out; the 2-bit field wraps on its own.
      if (w_edge[0] && !w_edge[1]) begin
        r_pend_mode <= r_pend_mode + 1'b1;
      end else if (w_edge[1] && !w_edge[0]) begin
        r_pend_mode <= r_pend_mode - 1'b1;
      end
      if (w_edge[2]) begin
        r_pend_inv <= ~r_pend_inv;
      end
      // Copies the pre-edge pending value, so an edge on this cycle waits
      // for the following frame.
      if (w_frame_tick) begin
        r_act_mode <= r_pend_mode;
        r_act_inv  <= r_pend_inv;
      end
    end
  end

  // Pixel (0,0) is rendered on the same tick that commits the pending
  // setting, so look ahead to it to keep the whole frame consistent.
  logic [MODE_W-1:0] w_mode;
  logic              w_inv;

  assign w_mode = w_frame_tick ? r_pend_mode : r_act_mode;
  assign w_inv  = w_frame_tick ? r_pend_inv  : r_act_inv;

  // Pattern generation
  logic [2:0]         w_bar;
  logic               w_chk;
  logic [COLOR_W-1:0] w_grad;
  logic [COLOR_W-1:0] w_red;
  logic [COLOR_W-1:0] w_green;
  logic [COLOR_W-1:0] w_blue;

  assign w_bar  = 3'(32'(w_h) / BAR_W);
  // Widened so bit 5 exists even for tiny test rasters.
  assign w_chk  = (((32'(w_h) ^ 32'(w_v)) >> 5) & 32'd1) != 32'd0;
  // Top COLOR_W bits of an XB-bit x, also valid when XB < COLOR_W.
  assign w_grad = COLOR_W'((32'(w_h) << COLOR_W) >> XB);

`ifdef VGA_BORDER_EN
  logic w_border;
  assign w_border = (w_h == '0) || (32'(w_h) == H_ACTIVE - 1) ||
                    (w_v == '0) || (32'(w_v) == V_ACTIVE - 1);
`endif

  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    w_red   = '0;
    w_green = '0;
    w_blue  = '0;
    case (w_mode)
      MODE_BARS: begin
        w_red   = {COLOR_W{BAR_TABLE[w_bar][2]}};
        w_green = {COLOR_W{BAR_TABLE[w_bar][1]}};
        w_blue  = {COLOR_W{BAR_TABLE[w_bar][0]}};
      end
      MODE_CHECK: begin
        w_red   = {COLOR_W{w_chk}};
        w_green = {COLOR_W{w_chk}};
        w_blue  = {COLOR_W{w_chk}};
      end
      MODE_GRAD: begin
        w_red   = w_grad;
        w_green = w_grad;
        w_blue  = w_grad;
      end
      default: begin
        w_red   = '1;
        w_green = '1;
        w_blue  = '1;
      end
    endcase
`ifdef VGA_BORDER_EN
    if (w_border) begin
      w_red   = '1;
      w_green = '1;
      w_blue  = '1;
    end
`endif
    if (w_inv) begin
      w_red   = ~w_red;
      w_green = ~w_green;
      w_blue  = ~w_blue;
    end
    // Blanking wins over inversion.
    if (!w_active) begin
      w_red   = '0;
      w_green = '0;
      w_blue  = '0;
    end
  end

  // Output registers: one pixel tick behind the counters
  logic               r_hsync;
  logic               r_vsync;
  logic               r_de;
  logic               r_frame_start;
  logic [COLOR_W-1:0] r_red;
  logic [COLOR_W-1:0] r_green;
  logic [COLOR_W-1:0] r_blue;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hsync       <= ~H_POL;
      r_vsync       <= ~V_POL;
      r_de          <= 1'b0;
      r_frame_start <= 1'b0;
      r_red         <= '0;
      r_green       <= '0;
      r_blue        <= '0;
    end else begin
      // Updated every clk so the pulse lasts one clk, not one pixel.
      r_frame_start <= w_frame_tick;
      if (w_pix_ce) begin
        r_hsync <= w_hs_act ? H_POL : ~H_POL;
        r_vsync <= w_vs_act ? V_POL : ~V_POL;
        r_de    <= w_active;
        r_red   <= w_red;
        r_green <= w_green;
        r_blue  <= w_blue;
      end
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign frame_start = r_frame_start;
  assign red         = r_red;
  assign green       = r_green;
  assign blue        = r_blue;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_pattern_gen
// Directed bench on a 12x7 raster with CLK_DIV=2 and 3-bit colour. Expected
// pixels are hand-written {de,hsync,vsync,R,G,B} values; hand sequences cover
// staged mode changes, inversion and mid-frame reset.
// -----------------------------------------------------------------------------
module tb_vga_pattern_gen;

  localparam int HT = 12;

  logic       clk;
  logic       rst;
  logic [2:0] bt;
  logic       hsync;
  logic       vsync;
  logic [2:0] red;
  logic [2:0] green;
  logic [2:0] blue;
  logic       de;
  logic       frame_start;

  vga_pattern_gen #(
    .CLK_DIV(2),
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .COLOR_W(3)
  ) dut (
    .clk(clk), .rst(rst), .bt(bt),
    .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue),
    .de(de), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         h;
    int         v;
    logic       de;
    logic       hs;
    logic       vs;
    logic [8:0] rgb;
  } vec_t;

  vec_t vecs[19];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;   // clocks since the last observed frame_start
  int   n_fs;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Pixel p is on the outputs for cycles 2p and 2p+1 after frame_start.
  task automatic advance_to(input int p);
    while (cyc < 2 * p) tick();
  endtask

  task automatic wait_fs(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_start && n < 400);
    cyc = 0;
  endtask

  task automatic sync_frame();
    int n;
    wait_fs(n);
    check("frame_start_seen", 32'(n <= 168), 32'd1);
  endtask

  task automatic check_pix(input string name, input int h, input int v,
                           input logic e_de, input logic e_hs, input logic e_vs,
                           input logic [8:0] e_rgb, input logic e_inv);
    logic [8:0] rgb;
    advance_to(v * HT + h);
    rgb = e_rgb;
`ifdef VGA_BORDER_EN
    if (e_de && (h == 0 || h == 7 || v == 0 || v == 3))
      rgb = e_inv ? 9'h000 : 9'h1FF;
`endif
    if (e_inv && !e_de) rgb = 9'h000;
    check($sformatf("%s(%0d,%0d)", name, h, v),
          32'({de, hsync, vsync, red, green, blue}),
          32'({e_de, e_hs, e_vs, rgb}));
  endtask

  task automatic pulse(input logic [2:0] b, input int p);
    advance_to(p);
    bt = b;
    tick();
    bt = 3'b000;
    repeat (4) tick();
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, 32'({hsync, vsync, de, frame_start, red, green, blue}),
          32'({1'b1, 1'b1, 1'b0, 1'b0, 9'h000}));
  endtask

  initial begin
    // Mode 0 reference frame: bars, porches and sync positions.
    vecs[0]  = '{0, 0, 1, 1, 1, 9'b000_000_000};
    vecs[1]  = '{1, 0, 1, 1, 1, 9'b000_000_111};
    vecs[2]  = '{2, 0, 1, 1, 1, 9'b000_111_000};
    vecs[3]  = '{3, 0, 1, 1, 1, 9'b000_111_111};
    vecs[4]  = '{4, 0, 1, 1, 1, 9'b111_000_000};
    vecs[5]  = '{5, 0, 1, 1, 1, 9'b111_000_111};
    vecs[6]  = '{6, 0, 1, 1, 1, 9'b111_111_000};
    vecs[7]  = '{7, 0, 1, 1, 1, 9'b111_111_111};
    vecs[8]  = '{8, 0, 0, 1, 1, 9'b0};
    vecs[9]  = '{9, 0, 0, 0, 1, 9'b0};
    vecs[10] = '{10, 0, 0, 0, 1, 9'b0};
    vecs[11] = '{11, 0, 0, 1, 1, 9'b0};
    vecs[12] = '{3, 2, 1, 1, 1, 9'b000_111_111};
    vecs[13] = '{7, 3, 1, 1, 1, 9'b111_111_111};
    vecs[14] = '{2, 4, 0, 1, 1, 9'b0};
    vecs[15] = '{0, 5, 0, 1, 0, 9'b0};
    vecs[16] = '{9, 5, 0, 0, 0, 9'b0};
    vecs[17] = '{11, 5, 0, 1, 0, 9'b0};
    vecs[18] = '{0, 6, 0, 1, 1, 9'b0};

    rst = 1'b1;
    bt  = 3'b000;
    repeat (3) tick();
    check_reset_outputs("reset_state");

    rst = 1'b0;
    wait_fs(n_fs);
    check("first_frame_start_clk", 32'(n_fs), 32'd2);
    wait_fs(n_fs);
    check("frame_period_clk", 32'(n_fs), 32'd168);

    for (int i = 0; i < 19; i++)
      check_pix("mode0", vecs[i].h, vecs[i].v, vecs[i].de, vecs[i].hs,
                vecs[i].vs, vecs[i].rgb, 1'b0);

    // next: still mode 0 for the rest of this frame, mode 1 afterwards
    sync_frame();
    check_pix("pre_next", 2, 0, 1, 1, 1, 9'b000_111_000, 1'b0);
    pulse(3'b001, 1 * HT);
    check_pix("held_mode0", 3, 2, 1, 1, 1, 9'b000_111_111, 1'b0);
    sync_frame();
    for (int h = 0; h < 8; h++)
      check_pix("mode1_row0", h, 0, 1, 1, 1, 9'b0, 1'b0);
    pulse(3'b001, 4 * HT);

    sync_frame();
    check_pix("mode2", 5, 1, 1, 1, 1, 9'b101_101_101, 1'b0);
    check_pix("mode2", 2, 2, 1, 1, 1, 9'b010_010_010, 1'b0);
    pulse(3'b001, 4 * HT);

    sync_frame();
    check_pix("mode3", 0, 0, 1, 1, 1, 9'h1FF, 1'b0);
    check_pix("mode3", 6, 2, 1, 1, 1, 9'h1FF, 1'b0);
    pulse(3'b001, 4 * HT);

    sync_frame();
    check_pix("wrap_mode0", 1, 1, 1, 1, 1, 9'b000_000_111, 1'b0);
    check_pix("wrap_mode0", 6, 1, 1, 1, 1, 9'b111_111_000, 1'b0);
    pulse(3'b010, 4 * HT);

    sync_frame();
    check_pix("prev_mode3", 2, 1, 1, 1, 1, 9'h1FF, 1'b0);
    pulse(3'b011, 4 * HT);

    sync_frame();
    check_pix("both_mode3", 2, 1, 1, 1, 1, 9'h1FF, 1'b0);
    check_pix("both_mode3", 4, 2, 1, 1, 1, 9'h1FF, 1'b0);
    pulse(3'b100, 4 * HT);

    sync_frame();
    check_pix("inv_mode3", 2, 1, 1, 1, 1, 9'h000, 1'b1);
    check_pix("inv_blank", 9, 1, 0, 0, 1, 9'h000, 1'b1);
    pulse(3'b001, 4 * HT);

    sync_frame();
    check_pix("inv_mode0", 1, 1, 1, 1, 1, 9'b111_111_000, 1'b1);
    check_pix("inv_mode0", 6, 2, 1, 1, 1, 9'b000_000_111, 1'b1);

    // One-cycle reset in the middle of a line
    advance_to(1 * HT + 4);
    rst = 1'b1;
    tick();
    check_reset_outputs("midframe_reset");
    rst = 1'b0;
    wait_fs(n_fs);
    check("restart_frame_start_clk", 32'(n_fs), 32'd2);
    check_pix("reset_mode0", 4, 0, 1, 1, 1, 9'b111_000_000, 1'b0);
    check_pix("reset_mode0", 1, 1, 1, 1, 1, 9'b000_000_111, 1'b0);
    wait_fs(n_fs);
    check("restart_period_clk", 32'(n_fs), 32'(168 - 2 * (HT + 1)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
